// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD_DFLT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DFLT  = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: ROM read port, fetch-buffer handshake toward decode, redirect input.
interface fetch_if #(
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]   rom_instr;
    logic              id_ready;
    logic              if_valid;
    logic [XLEN-1:0]   if_instr;
    logic [XLEN-1:0]   if_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    modport master (
        output rom_addr, if_valid, if_instr, if_pc,
        input  rom_instr, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_addr, if_valid, if_instr, if_pc,
        output rom_instr, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and a
// one-entry fetch buffer toward decode; handles redirects, halt word and bad targets.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 5,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DFLT,
    parameter logic [XLEN-1:0] HALT_WORD = HALT_WORD_DFLT,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    fetch_if.master          bus,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic              fetching;
    logic [XLEN-1:0]   fa;
    logic              bad_target;
    logic              do_load;

    // Redirects only steer the fetch address while actively fetching.
    assign fetching   = (state_q == RUN) || (state_q == DRAIN);
    assign fa         = (fetching && bus.redirect_valid) ? bus.redirect_pc : pc_q;
    assign bad_target = (fa[1:0] != 2'b00) || (fa[XLEN-1:ADDR_W+2] != '0);

    assign bus.rom_addr = fa[ADDR_W+1:2];
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign halted       = halted_q;
    assign fault        = fault_q;
    assign fetch_count  = fetch_count_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        do_load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                do_load = !if_valid_q || bus.id_ready || bus.redirect_valid;
            end
            DRAIN: begin
                // A redirect here means the halt word was on the wrong path.
                if (bus.redirect_valid) begin
                    do_load = 1'b1;
                end else if (bus.id_ready) begin
                    if_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = HALTED;
                end
            end
            default: begin
            end
        endcase

        if (do_load) begin
            if (bad_target) begin
                fault_d    = 1'b1;
                halted_d   = 1'b1;
                if_valid_d = 1'b0;
                state_d    = HALTED;
            end else begin
                if_valid_d = 1'b1;
                if_instr_d = bus.rom_instr;
                if_pc_d    = fa;
                pc_d       = fa + XLEN'(4);
                if (fetch_count_q != '1) begin
                    fetch_count_d = fetch_count_q + CNT_W'(1);
                end
                state_d = (bus.rom_instr == HALT_WORD) ? DRAIN : RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= XLEN'(NOP_INSTR);
            if_pc_q       <= RESET_PC;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction ROM (5-bit word address, 32-bit data, combinational read).
- Owns the program counter and drives the ROM address.
- Registers each fetched word into a one-entry fetch buffer with a valid/ready handshake toward decode.
- Applies branch/jump redirects from later stages, detects the halt word, and flags out-of-range or misaligned targets.

Parameters:
ADDR_W, 5, ROM word-address width (ROM holds 2**ADDR_W words)
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, first fetch address (byte address)
HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch
CNT_W, 16, fetch-counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin fetching at RESET_PC
rom_addr  out  ADDR_W  word address to ROM (combinational)
rom_instr  in  XLEN  ROM read data (same-cycle)
id_ready  in  1  decode accepts the buffered instruction this cycle
if_valid  out  1  fetch buffer holds a valid instruction
if_instr  out  XLEN  buffered instruction
if_pc  out  XLEN  byte PC of if_instr
redirect_valid  in  1  taken branch/jump; wrong-path flush
redirect_pc  in  XLEN  redirect target (byte address)
halted  out  1  fetch stopped (halt word retired or fault)
fault  out  1  sticky: bad fetch target
fetch_count  out  CNT_W  saturating count of instructions loaded into buffer

Behaviour:
- Reset (async, immediate at any time, including mid-stream) sets these values:
  - state=IDLE, pc=RESET_PC, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC.
  - halted=0, fault=0, fetch_count=0.
- States: IDLE, RUN, DRAIN, HALTED.
- Fetch address: fa = redirect_valid ? redirect_pc : pc. rom_addr = fa[ADDR_W+1:2] in every state; in IDLE/HALTED it is pc[ADDR_W+1:2].
- Load condition in RUN: load = !if_valid | id_ready | redirect_valid. Redirect always overwrites a stalled buffer, because that buffer holds a wrong-path instruction.
- IDLE:
  - start=1 -> RUN. The first load happens in the RUN cycle, so if_valid rises 2 edges after the start edge.
  - redirect_valid is ignored.
- RUN, on load:
  - Bad target: fa[1:0]!=0 or fa[XLEN-1:ADDR_W+2]!=0 -> fault<=1, halted<=1, if_valid<=0, state<=HALTED. Counter unchanged.
  - Otherwise: if_valid<=1, if_instr<=rom_instr, if_pc<=fa, pc<=fa+4, fetch_count<=fetch_count+1 (saturates at all-ones).
  - If rom_instr==HALT_WORD, also state<=DRAIN. The halt word is delivered to decode like any instruction.
- RUN, no load: all registers hold; rom_addr is stable.
- DRAIN: no further fetch; pc holds.
  - redirect_valid=1 takes priority: the halt was wrong-path. Perform a RUN-style load of fa and return to RUN, or go to HALTED on a bad target or another halt.
  - Otherwise, when id_ready=1: if_valid<=0, halted<=1, state<=HALTED.
- HALTED: terminal until reset. start and redirect_valid are ignored; if_valid=0; outputs frozen.
- Simultaneous start and redirect in IDLE: start wins; the redirect is dropped.
- Buffer behaviour: if_instr and if_pc change only on a load. Decode sees stable values while if_valid=1 and id_ready=0.
- Throughput: 1 instruction/cycle with id_ready tied high. Zero-bubble redirect: the target is visible in the buffer on the next edge.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/HALTED);
  - NOP_INSTR=32'h0000_0013;
  - HALT_WORD default;
  - RESET_PC default.
- No sub-module. The instruction ROM stays a sibling instance wired through rom_addr/rom_instr.
- The fetch buffer and the next-PC mux stay inline.

Test Plan:
1. Reset, start at cycle 1, id_ready=1 -> if_valid=1 at cycle 3 with if_pc=0, if_instr=rom[0]. Subsequent cycles give if_pc 4, 8, 12; fetch_count 1, 2, 3, 4.
2. With if_pc=8, hold id_ready=0 for 3 cycles -> if_pc=8, if_instr=rom[2], rom_addr=3 and fetch_count stable. Release -> if_pc=12 next edge.
3. id_ready=0, redirect_valid=1, redirect_pc=0x18 -> next edge if_pc=0x18, if_instr=rom[6]. Following load gives if_pc=0x1C.
4. rom[5]=FFFFFFFF, straight-line run -> if_pc=0x14 carries the halt word. With id_ready=0 it holds; id_ready=1 -> if_valid=0, halted=1. A later start or redirect has no effect.
5. In DRAIN, redirect_pc=0x18 -> halted stays 0, state back to RUN, next if_pc=0x18.
6. Fault cases:
   - redirect_pc=0x0000_0082 -> fault=1, halted=1, if_valid=0.
   - After reset, redirect_pc=0x80 -> fault=1.
   - Assert rst_n=0 mid-stream -> outputs reset asynchronously, before the next clock edge.
